hit_rate_histogram: RTL and testbench

Parametrised N-channel hit counter. It accumulates per-channel hit counts over a programmable acquisition window, then freezes the results into a readout bank. Counters support saturating or wrapping overflow, with a sticky overflow flag per channel. It sits after the trigger/discriminator buffer stage and feeds the rate readout path, replacing the fixed 2-channel free-running counter.

---
 rtl/hit_rate_histogram.sv | 110 +++++++++++
 tb/tb_hit_rate_histogram.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hit_rate_histogram.sv
// N-channel windowed hit counter: counts registered hits over a programmable window,
// then freezes the per-channel totals into a readout bank with sticky overflow flags.
module hit_rate_histogram #(
   parameter int NCH      = 8,
   parameter int CW       = 32,
   parameter int SELW     = 4,
   parameter int WINBITS  = 24,
   parameter int SATURATE = 1
) (
   input  logic               clkin,
   input  logic               resethist,
   input  logic [NCH-1:0]     hits,
   input  logic [WINBITS-1:0] window_len,
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic [SELW-1:0]    rd_sel,
   output logic [CW-1:0]      rd_data,
   output logic [NCH-1:0]     overflow
);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t             state;
   logic [NCH-1:0]     hits_q;
   logic [WINBITS-1:0] remaining;
   logic [CW-1:0]      live [NCH];
   logic [CW-1:0]      bank [NCH];
   logic [CW-1:0]      nxt_cnt [NCH];
   logic [NCH-1:0]     ovf_inc;
   logic [CW-1:0]      rd_mux;

   // Returns {overflow_event, next_value}; all-ones either sticks or wraps.
   function automatic logic [CW:0] bump(input logic [CW-1:0] v, input logic inc);
      if (!inc)
         return {1'b0, v};
      if (&v)
         return (SATURATE != 0) ? {1'b1, v} : {1'b1, {CW{1'b0}}};
      return {1'b0, v + 1'b1};
   endfunction

   always_comb begin
      for (int i = 0; i < NCH; i++)
         {ovf_inc[i], nxt_cnt[i]} = bump(live[i], hits_q[i]);
   end

   // Out-of-range selects fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCH; i++)
         if (rd_sel == SELW'(i))
            rd_mux = bank[i];
   end

   always_ff @(posedge clkin) begin
      if (resethist) begin
         state     <= IDLE;
         hits_q    <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= '0;
         rd_data   <= '0;
         for (int i = 0; i < NCH; i++) begin
            live[i] <= '0;
            bank[i] <= '0;
         end
      end else begin
         hits_q  <= hits;
         rd_data <= rd_mux;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  overflow <= '0;
                  for (int i = 0; i < NCH; i++)
                     live[i] <= '0;
                  if (window_len == '0) begin
                     // Empty window: publish an all-zero result immediately.
                     state <= DONE;
                     done  <= 1'b1;
                     for (int i = 0; i < NCH; i++)
                        bank[i] <= '0;
                  end else begin
                     state     <= COUNT;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                     remaining <= window_len;
                  end
               end
            end
            COUNT: begin
               overflow  <= overflow | ovf_inc;
               remaining <= remaining - 1'b1;
               for (int i = 0; i < NCH; i++)
                  live[i] <= nxt_cnt[i];
               // Last sample: freeze the post-increment values in the same edge.
               if (remaining == WINBITS'(1)) begin
                  for (int i = 0; i < NCH; i++)
                     bank[i] <= nxt_cnt[i];
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hit_rate_histogram.sv
// Directed bench for hit_rate_histogram: default config plus two CW=4 instances
// (saturating and wrapping) sharing the same stimulus.
module tb_hit_rate_histogram;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  hits;
   logic [23:0] window_len;
   logic        start;
   logic [3:0]  rd_sel;

   logic        busy_m, done_m;
   logic [31:0] rd_m;
   logic [7:0]  ovf_m;
   logic        busy_s, done_s, busy_w, done_w;
   logic [3:0]  rd_s, rd_w;
   logic [7:0]  ovf_s, ovf_w;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   hit_rate_histogram dut_m (
      .clkin(clk), .resethist(rst), .hits(hits), .window_len(window_len),
      .start(start), .busy(busy_m), .done(done_m), .rd_sel(rd_sel),
      .rd_data(rd_m), .overflow(ovf_m)
   );

   hit_rate_histogram #(.CW(4), .SATURATE(1)) dut_s (
      .clkin(clk), .resethist(rst), .hits(hits), .window_len(window_len),
      .start(start), .busy(busy_s), .done(done_s), .rd_sel(rd_sel),
      .rd_data(rd_s), .overflow(ovf_s)
   );

   hit_rate_histogram #(.CW(4), .SATURATE(0)) dut_w (
      .clkin(clk), .resethist(rst), .hits(hits), .window_len(window_len),
      .start(start), .busy(busy_w), .done(done_w), .rd_sel(rd_sel),
      .rd_data(rd_w), .overflow(ovf_w)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] sel);
      rd_sel = sel;
      tick();
   endtask

   initial begin
      rst = 1'b1; hits = '0; window_len = '0; start = 1'b0; rd_sel = '0;
      repeat (3) tick();
      rst = 1'b0;
      check_eq("reset_busy", busy_m, 0);
      check_eq("reset_done", done_m, 0);
      check_eq("reset_ovf", ovf_m, 0);
      check_eq("reset_rd", rd_m, 0);

      // Idle with hits asserted must not count.
      hits = 8'hFF;
      repeat (20) tick();
      check_eq("idle_busy", busy_m, 0);
      check_eq("idle_done", done_m, 0);
      check_eq("idle_ovf", ovf_m, 0);
      for (int s = 0; s < 16; s++) begin
         rd(4'(s));
         check_eq($sformatf("idle_rd%0d", s), rd_m, 0);
      end

      // Window of 10: ch0 held, ch3 toggling from 1 on the start edge.
      window_len = 24'd10;
      for (int k = 0; k < 10; k++) begin
         start = (k == 0);
         hits  = {4'b0, (k % 2 == 0), 2'b00, 1'b1};
         tick();
         if (k == 0) check_eq("w10_busy_rise", busy_m, 1);
      end
      start = 1'b0; hits = '0;
      check_eq("w10_not_done_early", done_m, 0);
      check_eq("w10_busy_late", busy_m, 1);
      tick();
      check_eq("w10_done", done_m, 1);
      check_eq("w10_busy_fall", busy_m, 0);
      rd(4'd0); check_eq("w10_ch0", rd_m, 10);
      rd(4'd3); check_eq("w10_ch3", rd_m, 5);
      rd(4'd1); check_eq("w10_ch1", rd_m, 0);
      rd(4'd7); check_eq("w10_ch7", rd_m, 0);
      check_eq("w10_ovf", ovf_m, 0);

      // Re-arm from DONE, with a start pulse mid-window that must be ignored.
      hits = 8'hFF; start = 1'b1; window_len = 24'd10;
      tick();
      check_eq("rearm_done_drop", done_m, 0);
      check_eq("rearm_busy", busy_m, 1);
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1; window_len = 24'd50;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check_eq("ign_not_done", done_m, 0);
      tick();
      check_eq("ign_done", done_m, 1);
      hits = '0;
      rd(4'd0); check_eq("ign_ch0", rd_m, 10);
      rd(4'd7); check_eq("ign_ch7", rd_m, 10);
      rd(4'd8); check_eq("rd_sel_nch", rd_m, 0);
      rd(4'd15); check_eq("rd_sel_max", rd_m, 0);

      // Zero-length window publishes zeros without asserting busy.
      hits = 8'hFF; start = 1'b1; window_len = '0;
      tick();
      start = 1'b0;
      check_eq("w0_done", done_m, 1);
      check_eq("w0_busy", busy_m, 0);
      for (int c = 0; c < 8; c++) begin
         rd(4'(c));
         check_eq($sformatf("w0_busy_c%0d", c), busy_m, 0);
         check_eq($sformatf("w0_ch%0d", c), rd_m, 0);
      end

      // 20 hits into 4-bit counters: saturate at 15 vs wrap to 4.
      hits = 8'h02; start = 1'b1; window_len = 24'd20;
      tick();
      start = 1'b0;
      repeat (20) tick();
      hits = '0;
      check_eq("c4_sat_done", done_s, 1);
      check_eq("c4_wrap_done", done_w, 1);
      rd(4'd1);
      check_eq("c4_sat_ch1", rd_s, 15);
      check_eq("c4_wrap_ch1", rd_w, 4);
      check_eq("c4_main_ch1", rd_m, 20);
      check_eq("c4_sat_ovf", ovf_s, 8'h02);
      check_eq("c4_wrap_ovf", ovf_w, 8'h02);
      check_eq("c4_main_ovf", ovf_m, 0);
      rd(4'd0);
      check_eq("c4_sat_ch0", rd_s, 0);

      // Start in DONE clears the sticky overflow.
      hits = 8'hFF; start = 1'b1; window_len = 24'd3;
      tick();
      start = 1'b0;
      check_eq("rearm_ovf_clr_s", ovf_s, 0);
      check_eq("rearm_ovf_clr_w", ovf_w, 0);
      repeat (3) tick();
      check_eq("w3a_done", done_m, 1);

      // Reset on cycle 5 of a 100-cycle window.
      start = 1'b1; window_len = 24'd100;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_eq("pre_rst_busy", busy_m, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_busy", busy_m, 0);
      check_eq("mid_rst_done", done_m, 0);
      check_eq("mid_rst_ovf", ovf_m, 0);
      rd(4'd0); check_eq("mid_rst_bank0", rd_m, 0);
      rd(4'd5); check_eq("mid_rst_bank5", rd_m, 0);
      repeat (5) tick();
      check_eq("mid_rst_stays_idle", busy_m, 0);

      start = 1'b1; window_len = 24'd3;
      tick();
      start = 1'b0;
      repeat (2) tick();
      check_eq("w3_not_done", done_m, 0);
      tick();
      check_eq("w3_done", done_m, 1);
      hits = '0;
      for (int c = 0; c < 8; c++) begin
         rd(4'(c));
         check_eq($sformatf("w3_ch%0d", c), rd_m, 3);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
